// File: rtl/pixel_window_buf_pkg.sv
// Shared sizing constants, FSM state encoding and window indexing for the
// sliding-window line buffer.
package pixel_window_buf_pkg;

   localparam int MAXIMG = 32;
   localparam int MAXFIL = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_ERR
   } state_t;

   // Flat element index of window position (i,j).
   function automatic int win_idx(input int i, input int j);
      return i * MAXFIL + j;
   endfunction

endpackage

// File: rtl/pixel_window_buf_line_ring.sv
// One circular image line: combinational read of the old word at addr,
// with the new word written at the same addr on the clock edge.
module pixel_window_buf_line_ring
   import pixel_window_buf_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = $clog2(MAXIMG)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [AWIDTH-1:0]        addr,
   input  logic signed [DWIDTH-1:0] wdata,
   output logic signed [DWIDTH-1:0] rdata
);

   logic signed [DWIDTH-1:0] mem [MAXIMG];

   // NOTE: storage arrays get no reset; every word is written before any output depends on it.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/pixel_window_buf.sv
// Sliding-window line buffer: turns a raster pixel stream into one
// fil_size x fil_size window per valid output position.
module pixel_window_buf
   import pixel_window_buf_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int LWIDTH = 10
) (
   input  logic                              clk,
   input  logic                              xrst,
   input  logic                              frame_start,
   input  logic [LWIDTH-1:0]                 img_size,
   input  logic [LWIDTH-1:0]                 fil_size,
   input  logic                              pix_en,
   input  logic signed [DWIDTH-1:0]          pixel,
   output logic                              win_valid,
   output logic [MAXFIL*MAXFIL*DWIDTH-1:0]   window,
   output logic [LWIDTH-1:0]                 win_x,
   output logic [LWIDTH-1:0]                 win_y,
   output logic                              frame_done,
   output logic                              cfg_err
);

   localparam int AW = $clog2(MAXIMG);
   localparam int NL = MAXFIL - 1;

   state_t                   state, state_nxt;
   logic [LWIDTH-1:0]        img_q, fil_q, col, row;
   logic signed [DWIDTH-1:0] win_r   [MAXFIL][MAXFIL];
   logic signed [DWIDTH-1:0] line_rd [NL];
   logic signed [DWIDTH-1:0] col_new [MAXFIL];
   logic                     cfg_ok, accept, col_last, last_pix, at_win;

   assign cfg_ok   = (fil_size != '0) && (fil_size <= img_size) &&
                     (img_size <= LWIDTH'(MAXIMG)) && (fil_size <= LWIDTH'(MAXFIL));
   assign accept   = (state == S_ACTIVE) && pix_en && !frame_start;
   assign col_last = (col == img_q - LWIDTH'(1));
   assign last_pix = col_last && (row == img_q - LWIDTH'(1));
   assign at_win   = (col >= fil_q - LWIDTH'(1)) && (row >= fil_q - LWIDTH'(1));

   // Line k holds row-1-k; each accept pushes the column down the chain.
   for (genvar k = 0; k < NL; k++) begin : g_line
      logic signed [DWIDTH-1:0] wd;
      if (k == 0) begin : g_head
         assign wd = pixel;
      end else begin : g_tail
         assign wd = line_rd[k-1];
      end
      pixel_window_buf_line_ring #(.DWIDTH(DWIDTH), .AWIDTH(AW)) u_line (
         .clk   (clk),
         .we    (accept),
         .addr  (col[AW-1:0]),
         .wdata (wd),
         .rdata (line_rd[k])
      );
   end

   // NOTE: every combinational output is defaulted first so no path can infer a latch.
   always_comb begin
      for (int i = 0; i < MAXFIL; i++) col_new[i] = '0;
      for (int i = 0; i < MAXFIL; i++) begin
         if (LWIDTH'(i) == fil_q - LWIDTH'(1)) col_new[i] = pixel;
         for (int k = 0; k < NL; k++) begin
            if (LWIDTH'(i + k + 2) == fil_q) col_new[i] = line_rd[k];
         end
      end
   end

   // A legal frame_start always restarts a frame, including out of S_ERR.
   always_comb begin
      state_nxt = state;
      if (frame_start)             state_nxt = cfg_ok ? S_ACTIVE : S_ERR;
      else if (accept && last_pix) state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (xrst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         img_q      <= '0;
         fil_q      <= '0;
         col        <= '0;
         row        <= '0;
         win_valid  <= 1'b0;
         win_x      <= '0;
         win_y      <= '0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
         for (int i = 0; i < MAXFIL; i++)
            for (int j = 0; j < MAXFIL; j++) win_r[i][j] <= '0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (frame_start) begin
            img_q   <= img_size;
            fil_q   <= fil_size;
            col     <= '0;
            row     <= '0;
            cfg_err <= !cfg_ok;
         end else if (accept) begin
            col <= col_last ? '0 : col + LWIDTH'(1);
            if (col_last) row <= row + LWIDTH'(1);
            for (int i = 0; i < MAXFIL; i++) begin
               for (int j = 0; j < MAXFIL - 1; j++)
                  if (LWIDTH'(j) < fil_q - LWIDTH'(1)) win_r[i][j] <= win_r[i][j+1];
               for (int j = 0; j < MAXFIL; j++)
                  if (LWIDTH'(j) == fil_q - LWIDTH'(1)) win_r[i][j] <= col_new[i];
            end
            win_valid  <= at_win;
            frame_done <= last_pix;
            if (at_win) begin
               win_x <= col - fil_q + LWIDTH'(1);
               win_y <= row - fil_q + LWIDTH'(1);
            end
         end
      end
   end

   // Positions outside the programmed filter read as zero.
   always_comb begin
      window = '0;
      for (int i = 0; i < MAXFIL; i++)
         for (int j = 0; j < MAXFIL; j++)
            if (LWIDTH'(i) < fil_q && LWIDTH'(j) < fil_q)
               window[win_idx(i, j)*DWIDTH +: DWIDTH] = win_r[i][j];
   end

endmodule

// File: tb/tb_pixel_window_buf.sv
// Scoreboard bench for pixel_window_buf: the driver pushes expected windows,
// a negedge monitor pops and compares whenever win_valid is seen.
module tb_pixel_window_buf;
   import pixel_window_buf_pkg::*;

   localparam int DW = 16;
   localparam int LW = 10;
   localparam int WW = MAXFIL * MAXFIL * DW;

   logic                 clk = 1'b0;
   logic                 xrst, frame_start, pix_en;
   logic [LW-1:0]        img_size, fil_size;
   logic signed [DW-1:0] pixel;
   logic                 win_valid, frame_done, cfg_err;
   logic [WW-1:0]        window;
   logic [LW-1:0]        win_x, win_y;

   pixel_window_buf #(.DWIDTH(DW), .LWIDTH(LW)) dut (
      .clk         (clk),
      .xrst        (xrst),
      .frame_start (frame_start),
      .img_size    (img_size),
      .fil_size    (fil_size),
      .pix_en      (pix_en),
      .pixel       (pixel),
      .win_valid   (win_valid),
      .window      (window),
      .win_x       (win_x),
      .win_y       (win_y),
      .frame_done  (frame_done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            x;
      int            y;
      logic [WW-1:0] w;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   total = 0, bad = 0, done_seen = 0, done_exp = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // mode 0: sequential raster index; mode 1: 100*row+col.
   function automatic int pv(input int mode, input int img, input int r, input int c);
      return (mode == 0) ? r * img + c : 100 * r + c;
   endfunction

   task automatic cyc(input logic fs, input logic en, input int px);
      @(posedge clk);
      #1;
      frame_start = fs;
      pix_en      = en;
      pixel       = DW'(px);
   endtask

   task automatic push_win(input int img, input int fil, input int mode, input int r, input int c);
      exp_t e;
      e.x = c - fil + 1;
      e.y = r - fil + 1;
      e.w = '0;
      for (int i = 0; i < fil; i++)
         for (int j = 0; j < fil; j++)
            e.w[(i*MAXFIL+j)*DW +: DW] = DW'(pv(mode, img, e.y + i, e.x + j));
      sb.push_back(e);
   endtask

   // Sends count pixels; a complete legal frame also checks frame_done timing.
   task automatic run_frame(input int img, input int fil, input int mode,
                            input bit gap, input int count, input bit legal);
      img_size = LW'(img);
      fil_size = LW'(fil);
      cyc(1'b1, 1'b0, 0);
      for (int n = 0; n < count; n++) begin
         int r, c;
         r = n / img;
         c = n % img;
         if (gap && n > 0) cyc(1'b0, 1'b0, 16'h7abc);
         if (legal && r >= fil - 1 && c >= fil - 1) push_win(img, fil, mode, r, c);
         cyc(1'b0, 1'b1, pv(mode, img, r, c));
      end
      if (count == img * img || !legal) begin
         cyc(1'b0, 1'b0, 0);
         @(negedge clk);
         check("cfg_err", cfg_err, legal ? 0 : 1);
         if (legal) begin
            check("frame_done_pulse", frame_done, 1);
            done_exp++;
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_win_valid"}, win_valid, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_win_x"}, win_x, 0);
      check({tag, "_win_y"}, win_y, 0);
      check({tag, "_window_zero"}, longint'(window == '0), 1);
   endtask

   always @(negedge clk) begin
      if (frame_done) done_seen++;
      if (win_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_win_valid", 1, 0);
         end else begin
            m_e = sb.pop_front();
            check("win_x", win_x, m_e.x);
            check("win_y", win_y, m_e.y);
            total++;
            if (window !== m_e.w) begin
               bad++;
               $display("FAIL window(%0d,%0d): got %h expected %h", m_e.x, m_e.y, window, m_e.w);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached with %0d windows pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      xrst = 1'b1;
      frame_start = 1'b0;
      pix_en = 1'b0;
      pixel = '0;
      img_size = '0;
      fil_size = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      @(posedge clk);
      #1 xrst = 1'b0;

      // img=4 fil=3: four windows, continuous then with gaps
      run_frame(4, 3, 0, 1'b0, 16, 1'b1);
      run_frame(4, 3, 0, 1'b1, 16, 1'b1);

      // Full-size image, full and reduced filter
      run_frame(32, 5, 1, 1'b0, 1024, 1'b1);
      run_frame(32, 3, 1, 1'b0, 1024, 1'b1);

      // Single-tap filter
      run_frame(3, 1, 0, 1'b0, 9, 1'b1);

      // Illegal configs, then recovery
      run_frame(4, 6, 0, 1'b0, 40, 1'b0);
      run_frame(4, 5, 0, 1'b0, 40, 1'b0);
      run_frame(4, 0, 0, 1'b0, 8, 1'b0);
      run_frame(4, 3, 0, 1'b0, 16, 1'b1);

      // Abort after pixel 7, then a full frame
      run_frame(4, 3, 0, 1'b0, 8, 1'b1);
      run_frame(4, 3, 0, 1'b0, 16, 1'b1);

      // Reset mid-frame after pixel 9
      run_frame(4, 3, 0, 1'b0, 10, 1'b1);
      @(posedge clk);
      #1;
      xrst = 1'b1;
      pix_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_cleared("midreset");
      @(posedge clk);
      #1 xrst = 1'b0;
      run_frame(4, 3, 0, 1'b1, 16, 1'b1);

      repeat (4) @(negedge clk);
      check("windows_outstanding", sb.size(), 0);
      check("frame_done_count", done_seen, done_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
